// File: rtl/heap_arena_pkg.sv
// Shared types for the heap arena server: request opcodes, FSM states and
// response codes.
package heap_arena_pkg;

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_MOVE  = 3'd2,
    OP_ALLOC = 3'd3,
    OP_FREE  = 3'd4,
    OP_SIZE  = 3'd5
  } heap_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESP    = 2'd1,
    ST_MOVE_RD = 2'd2,
    ST_MOVE_WR = 2'd3
  } heap_state_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/heap_arena_ram.sv
// Single-port synchronous arena RAM: write-first, registered read data.
module heap_arena_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 64
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One access per cycle; a write also forwards its data to the output.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/heap_arena_server.sv
// Heap arena server: services one heap request at a time against the arena
// RAM and owns the per-array size table and the freed-array stack.
// Optional request checking is enabled by defining HEAP_ARENA_SERVER_BOUNDS_EN.
module heap_arena_server
  import heap_arena_pkg::*;
#(
  parameter  int DATA_WIDTH = 12,
  parameter  int N_AREA     = 16,
  parameter  int N_ARRAYS   = 4,
  localparam int AW         = $clog2(N_ARRAYS),
  localparam int IW         = $clog2(N_AREA)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [AW-1:0]         req_array,
  input  logic [IW-1:0]         req_index,
  input  logic [AW-1:0]         req_src_array,
  input  logic [IW-1:0]         req_src_index,
  input  logic [IW:0]           req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error
);

  localparam int DEPTH = N_AREA * N_ARRAYS;

  heap_state_t           state_q, state_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_error_q, resp_error_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_ram_q, resp_ram_d;   // resp_data comes from the RAM this cycle
  logic [AW-1:0]         mv_src_a_q, mv_src_a_d, mv_dst_a_q, mv_dst_a_d;
  logic [IW-1:0]         mv_src_i_q, mv_src_i_d, mv_dst_i_q, mv_dst_i_d;
  logic [IW:0]           mv_len_q, mv_len_d, mv_k_q, mv_k_d;
  logic [AW:0]           allocs_q, allocs_d, sp_q, sp_d, sp_top;
  logic [AW-1:0]         stack_q [N_ARRAYS];
  logic [AW-1:0]         stack_d [N_ARRAYS];
  logic [IW:0]           size_q [N_ARRAYS];
  logic [IW:0]           size_d [N_ARRAYS];

  logic                  ram_we;
  logic [AW+IW-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic [IW:0]           wr_end, mv_end;
  logic [AW-1:0]         alloc_id;
  logic                  req_bad;

  // Writes are suppressed while reset is high so an aborted move stops at once.
  heap_arena_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .we    (ram_we & ~reset),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign wr_end = {1'b0, req_index} + 1'b1;
  assign mv_end = {1'b0, req_index} + req_len;
  assign sp_top = sp_q - 1'b1;

`ifdef HEAP_ARENA_SERVER_BOUNDS_EN
  logic [IW:0] src_end;
  logic        on_stack;
  assign src_end = {1'b0, req_src_index} + req_len;

  // Reject unallocated ids, out-of-area moves and double frees.
  always_comb begin
    on_stack = 1'b0;
    for (int i = 0; i < N_ARRAYS; i++) begin
      if ((AW+1)'(i) < sp_q && stack_q[i] == req_array) on_stack = 1'b1;
    end
    req_bad = 1'b0;
    if (req_op != OP_ALLOC && {1'b0, req_array} >= allocs_q) req_bad = 1'b1;
    if (req_op == OP_MOVE && ({1'b0, req_src_array} >= allocs_q ||
        mv_end > (IW+1)'(N_AREA) || src_end > (IW+1)'(N_AREA))) req_bad = 1'b1;
    if (req_op == OP_FREE && on_stack) req_bad = 1'b1;
  end
`else
  assign req_bad = 1'b0;
`endif

  // Next-state logic for the request FSM, move engine, size table and stack.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_error_d = resp_error_q;
    resp_data_d  = resp_data_q;
    resp_ram_d   = resp_ram_q;
    mv_src_a_d   = mv_src_a_q;
    mv_src_i_d   = mv_src_i_q;
    mv_dst_a_d   = mv_dst_a_q;
    mv_dst_i_d   = mv_dst_i_q;
    mv_len_d     = mv_len_q;
    mv_k_d       = mv_k_q;
    allocs_d     = allocs_q;
    sp_d         = sp_q;
    stack_d      = stack_q;
    size_d       = size_q;
    ram_we       = 1'b0;
    ram_addr     = {req_array, req_index};
    ram_wdata    = req_wdata;
    alloc_id     = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_error_d = RESP_OK;
          resp_data_d  = '0;
          if (req_bad) begin
            resp_error_d = RESP_ERR;
          end else begin
            case (heap_op_t'(req_op))
              OP_READ: resp_ram_d = 1'b1;
              OP_WRITE: begin
                ram_we = 1'b1;
                if (wr_end > size_q[req_array]) size_d[req_array] = wr_end;
              end
              OP_MOVE: begin
                if (req_len != '0) begin
                  // Response registers keep their old values until the move completes.
                  state_d      = ST_MOVE_RD;
                  resp_valid_d = 1'b0;
                  resp_error_d = resp_error_q;
                  resp_data_d  = resp_data_q;
                  mv_src_a_d   = req_src_array;
                  mv_src_i_d   = req_src_index;
                  mv_dst_a_d   = req_array;
                  mv_dst_i_d   = req_index;
                  mv_len_d     = req_len;
                  mv_k_d       = '0;
                  if (mv_end > size_q[req_array]) size_d[req_array] = mv_end;
                end
              end
              OP_ALLOC: begin
                if (sp_q != '0) begin
                  alloc_id = stack_q[sp_top[AW-1:0]];
                  sp_d     = sp_top;
                end else if (allocs_q < (AW+1)'(N_ARRAYS)) begin
                  alloc_id = allocs_q[AW-1:0];
                  allocs_d = allocs_q + 1'b1;
                end else begin
                  resp_error_d = RESP_ERR;
                end
                if (resp_error_d == RESP_OK) begin
                  size_d[alloc_id] = '0;
                  resp_data_d      = DATA_WIDTH'(alloc_id);
                end
              end
              OP_FREE: begin
                if (sp_q < (AW+1)'(N_ARRAYS)) begin
                  stack_d[sp_q[AW-1:0]] = req_array;
                  sp_d                  = sp_q + 1'b1;
                end
              end
              OP_SIZE: resp_data_d = DATA_WIDTH'(size_q[req_array]);
              default: resp_error_d = RESP_ERR;
            endcase
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (resp_ram_q) begin
          resp_data_d = ram_rdata;
          resp_ram_d  = 1'b0;
        end
      end
      ST_MOVE_RD: begin
        ram_addr = {mv_src_a_q, mv_src_i_q + mv_k_q[IW-1:0]};
        state_d  = ST_MOVE_WR;
      end
      ST_MOVE_WR: begin
        ram_we    = 1'b1;
        ram_addr  = {mv_dst_a_q, mv_dst_i_q + mv_k_q[IW-1:0]};
        ram_wdata = ram_rdata;
        mv_k_d    = mv_k_q + 1'b1;
        if (mv_k_q == mv_len_q - 1'b1) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_error_d = RESP_OK;
          resp_data_d  = '0;
        end else begin
          state_d = ST_MOVE_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; memory contents and stack entries are not cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
      resp_ram_q   <= 1'b0;
      allocs_q     <= '0;
      sp_q         <= '0;
      for (int i = 0; i < N_ARRAYS; i++) size_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_data_q  <= resp_data_d;
      resp_ram_q   <= resp_ram_d;
      allocs_q     <= allocs_d;
      sp_q         <= sp_d;
      for (int i = 0; i < N_ARRAYS; i++) size_q[i] <= size_d[i];
    end
    mv_src_a_q <= mv_src_a_d;
    mv_src_i_q <= mv_src_i_d;
    mv_dst_a_q <= mv_dst_a_d;
    mv_dst_i_q <= mv_dst_i_d;
    mv_len_q   <= mv_len_d;
    mv_k_q     <= mv_k_d;
    for (int i = 0; i < N_ARRAYS; i++) stack_q[i] <= stack_d[i];
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_data  = resp_ram_q ? ram_rdata : resp_data_q;

endmodule

// File: doc/heap_arena_server.md
# heap_arena_server

Responder end of the heap access protocol used by the generated test-program FSMs. It accepts one request at a time from an instruction-stepping initiator and services it against a single-port arena memory. Supported operations are read, write, block move (moveLong), array allocate/free, and array-size query. It owns the per-array size table and the freed-array stack, so initiators no longer track them inline.

## Interface
- DATA_WIDTH, 12: heap word width.
- N_AREA, 16: words per array area; power of two.
- N_ARRAYS, 4: maximum number of arrays; power of two.
- Derived values: AW = $clog2(N_ARRAYS), IW = $clog2(N_AREA), heap depth N_AREA*N_ARRAYS.
- Reset: `reset`, synchronous, active-high. Clock: `clock`.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  server idle; a request is accepted when req_valid && req_ready.
- req_op  in  3  0 READ, 1 WRITE, 2 MOVE, 3 ALLOC, 4 FREE, 5 SIZE; 6 and 7 are illegal.
- req_array  in  AW  target array (destination for MOVE).
- req_index  in  IW  target word index.
- req_src_array  in  AW  MOVE source array.
- req_src_index  in  IW  MOVE source index.
- req_len  in  IW+1  MOVE word count, 0..N_AREA.
- req_wdata  in  DATA_WIDTH  WRITE data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  DATA_WIDTH  READ word, ALLOC id, or SIZE value; 0 for other ops.
- resp_error  out  1  qualifies resp_valid.

## Operation
- States: IDLE, RESP, MOVE_RD, MOVE_WR. req_ready = (state == IDLE).
- Word address = array*N_AREA + index, formed by concatenation.
- READ, WRITE, ALLOC, FREE, SIZE: from IDLE to RESP for one cycle, then back to IDLE.
- WRITE: updates memory and sets size[array] = max(size[array], index+1).
- MOVE, len 0: goes straight to RESP and touches nothing.
- MOVE, len > 0: enters MOVE_RD and alternates MOVE_RD/MOVE_WR.
  - MOVE_RD reads src+k.
  - MOVE_WR writes that word to dst+k, then increments k.
  - After word len-1 goes to RESP.
  - Sets size[dst] = max(size[dst], dst_index+len).
- MOVE copies in ascending order. An overlapping forward move in the same array replicates source words; this is defined behaviour.
- ALLOC:
  - If the freed stack is non-empty, pops it (LIFO).
  - Otherwise, if allocs < N_ARRAYS, returns allocs and increments allocs.
  - Otherwise resp_error=1 and resp_data=0.
  - On success, size[id]=0.
- FREE: pushes req_array onto the freed stack. The stack depth is N_ARRAYS, so it cannot overflow when frees are legal.
- SIZE: returns size[req_array], zero-extended.
- Illegal op: RESP with resp_error=1 and no side effects.
- Reset values:
  - Outputs: req_ready=1, resp_valid=0, resp_data=0, resp_error=0.
  - Internal: allocs=0, stack empty, all sizes 0.
  - Memory contents are not cleared.
- Reset mid-MOVE aborts immediately. Words already written stay written, and no response is issued.

## Timing
- Accept in cycle N.
- Non-MOVE ops and MOVE with len 0: resp_valid in cycle N+1, req_ready=1 again in N+2.
- MOVE with len L>0: resp_valid in cycle N+2L+1.
- Memory has one-cycle read latency. READ data is registered into resp_data in the RESP cycle.
- resp_data and resp_error hold their values until the next resp_valid.
- req_valid while busy is ignored. The initiator holds its request until it is accepted.

## Configuration
- HEAP_ARENA_SERVER_BOUNDS_EN defined: the following requests complete in RESP with resp_error=1 and no memory, size or stack change:
  - any req_array or req_src_array >= allocs;
  - MOVE with index+len > N_AREA on either side;
  - FREE of an id already on the stack.
- Undefined: no checks are made and indices wrap modulo N_AREA within the area. resp_error is raised only for ALLOC exhaustion and illegal ops.

## Structure
- Package heap_arena_pkg holds the op enum (heap_op_t), the state enum, and response-code constants.
- One sub-module, heap_arena_ram: single-port synchronous RAM, write-first, registered output, parameterised by DATA_WIDTH and depth.
- The size table and freed stack are flop arrays inside heap_arena_server.

## Test plan
- Reset, then ALLOC ×3 with N_ARRAYS=2: resp_data 0, then 1, then resp_error=1. Each resp_valid arrives exactly 1 cycle after accept.
- WRITE array0 index i = i for i=0..9, then READ array0 index4: resp_data=4. A following SIZE array0 returns 10.
- WRITE array0 index i = i+100 for i=0..2, then MOVE src a0/0 to dst a1/0 with len 3: resp_valid 7 cycles after accept. READ a1/2 returns 102; SIZE a1 returns 3.
- FREE 1 then ALLOC: returns 1. SIZE 1 returns 0. The next ALLOC returns resp_error=1.
- With BOUNDS_EN, MOVE dst index 14 len 3: resp_error=1 and a1/14 unchanged. Without BOUNDS_EN, the third word lands at a1/0.
- Assert reset during the second MOVE_WR of a len-4 move: the next cycle has req_ready=1 and resp_valid=0, and a following ALLOC returns 0.
